// File: rtl/mdu_iterative.sv
// mdu_iterative: multi-cycle MULT/MULTU/DIV/DIVU unit for the EX stage.
// Multiply takes MUL_CYCLES busy cycles, divide is radix-2 restoring with
// one quotient bit per busy cycle. Results land in HI/LO on the BUSY->DONE edge.
// Optional feature macro: MDU_EARLY_OUT_EN (short-circuits trivial divides).
module mdu_iterative #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             ALU_stall,
  output logic             ALU_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // Counter must hold both WIDTH and the largest legal MUL_CYCLES (15).
  localparam int CW = $clog2(WIDTH + 16);
  localparam logic [CW-1:0] DIV_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_op;      // op[1]=divide, op[0]=unsigned
  logic [WIDTH-1:0] r_a;       // multiplicand, or dividend/quotient shift register
  logic [WIDTH-1:0] r_b;       // multiplier, or divisor magnitude
  logic [WIDTH-1:0] r_rem;     // partial remainder
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
`ifdef MDU_EARLY_OUT_EN
  logic             r_early;
`endif

  // Operand magnitudes at accept; unsigned ops never negate.
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_accept;

  assign w_a_neg  = ~op[0] & src_a[WIDTH-1];
  assign w_b_neg  = ~op[0] & src_b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? (~src_a + 1'b1) : src_a;
  assign w_b_mag  = w_b_neg ? (~src_b + 1'b1) : src_b;
  assign w_accept = (r_state == S_IDLE) && start && !flush;

`ifdef MDU_EARLY_OUT_EN
  // Quotient is trivially known when the divisor is zero or exceeds the dividend.
  logic w_early;
  assign w_early = (w_b_mag == '0) || (w_a_mag < w_b_mag);
`endif

  // Product of the captured operands, extended according to signedness.
  logic [2*WIDTH-1:0] w_ext_a;
  logic [2*WIDTH-1:0] w_ext_b;
  logic [2*WIDTH-1:0] w_prod;

  assign w_ext_a = r_op[0] ? {{WIDTH{1'b0}}, r_a} : {{WIDTH{r_a[WIDTH-1]}}, r_a};
  assign w_ext_b = r_op[0] ? {{WIDTH{1'b0}}, r_b} : {{WIDTH{r_b[WIDTH-1]}}, r_b};
  assign w_prod  = w_ext_a * w_ext_b;

  // One restoring step: shift next dividend bit in, trial-subtract the divisor.
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_qbit;
  logic [WIDTH-1:0] w_rem_step;
  logic [WIDTH-1:0] w_quo_step;

  assign w_shift    = {r_rem, r_a[WIDTH-1]};
  assign w_diff     = w_shift - {1'b0, r_b};
  assign w_qbit     = ~w_diff[WIDTH];
  assign w_rem_step = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quo_step = {r_a[WIDTH-2:0], w_qbit};

  // Final HI/LO values presented on the last busy cycle.
  logic [WIDTH-1:0] w_q_mag;
  logic [WIDTH-1:0] w_r_mag;
  logic [WIDTH-1:0] w_hi_res;
  logic [WIDTH-1:0] w_lo_res;

  // Select magnitudes, apply signed fix-up, or slice the product.
  always_comb begin
    w_q_mag = w_quo_step;
    w_r_mag = w_rem_step;
`ifdef MDU_EARLY_OUT_EN
    if (r_early) begin
      w_q_mag = (r_b == '0) ? '1 : '0;
      w_r_mag = r_a;
    end
`endif
    if (r_op[1]) begin
      w_hi_res = r_neg_r ? (~w_r_mag + 1'b1) : w_r_mag;
      w_lo_res = r_neg_q ? (~w_q_mag + 1'b1) : w_q_mag;
    end else begin
      w_hi_res = w_prod[2*WIDTH-1:WIDTH];
      w_lo_res = w_prod[WIDTH-1:0];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state and handshake outputs; flush wins over everything.
  always_comb begin
    w_state_next = r_state;
    ALU_stall    = 1'b0;
    ALU_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        ALU_stall = start;
        if (w_accept) w_state_next = S_BUSY;
      end
      S_BUSY: begin
        ALU_stall = 1'b1;
        if (r_cnt == CNT_ONE) w_state_next = S_DONE;
      end
      S_DONE: begin
        ALU_stall    = 1'b1;
        ALU_done     = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    if (flush) w_state_next = S_IDLE;
  end

  // Datapath: capture at accept, iterate while busy, commit HI/LO on the last cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_rem   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
`ifdef MDU_EARLY_OUT_EN
      r_early <= 1'b0;
`endif
    end else if (flush) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_op    <= op;
      r_rem   <= '0;
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
      if (op[1]) begin
        r_a   <= w_a_mag;
        r_b   <= w_b_mag;
        r_cnt <= DIV_LOAD;
`ifdef MDU_EARLY_OUT_EN
        r_early <= w_early;
        if (w_early) r_cnt <= CNT_ONE;
`endif
      end else begin
        r_a   <= src_a;
        r_b   <= src_b;
        r_cnt <= MUL_LOAD;
`ifdef MDU_EARLY_OUT_EN
        r_early <= 1'b0;
`endif
      end
    end else if (r_state == S_BUSY) begin
      r_cnt <= r_cnt - CNT_ONE;
      if (r_op[1]) begin
        r_a   <= w_quo_step;
        r_rem <= w_rem_step;
      end
      if (r_cnt == CNT_ONE) begin
        r_hi <= w_hi_res;
        r_lo <= w_lo_res;
      end
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule
